// File: rtl/psum_accumulator.sv
// Adder-side depacketizer: gathers one psum per PE for the current output neurone,
// integrates it into that neurone's membrane potential, thresholds it and emits the result.
module psum_accumulator #(
    parameter int unsigned WIDTH      = 35,
    parameter logic [2:0]  ADDER_ADDR = 3'b000,
    parameter int unsigned NUM_PE     = 3,
    parameter int unsigned NUM_OUT    = 3,
    parameter int unsigned VW         = 12,
    parameter int unsigned THRESHOLD  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_packet,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_spike,
    output logic [VW-1:0]    out_vmem,
    output logic [1:0]       out_idx,
    output logic [7:0]       out_tstep,
    output logic             err_dest,
    output logic             err_src,
    output logic             err_dup
);

    localparam int unsigned SW = VW + 2;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] SUM     = 2'd1;
    localparam logic [1:0] OUTPUT  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [NUM_PE-1:0] mask;
    logic [NUM_PE-1:0] src_hot;
    logic [7:0]        psum [NUM_PE];
    logic [VW-1:0]     vmem [NUM_OUT];
    logic [1:0]        idx;
    logic [7:0]        tstep;

    logic [2:0]        dest;
    logic [2:0]        src;
    logic [7:0]        data;
    logic              xfer;
    logic              dest_bad;
    logic              src_bad;
    logic              dup;
    logic              accept;
    logic              complete;
    logic [VW-1:0]     v_cur;
    logic [SW-1:0]     sum;
    logic [VW-1:0]     v_sat;
    logic [VW-1:0]     v_new;
    logic              spike;
    logic              unused_bits;

    assign dest        = in_packet[WIDTH-1 -: 3];
    assign src         = in_packet[WIDTH-4 -: 3];
    assign data        = in_packet[7:0];
    assign unused_bits = ^in_packet[WIDTH-7:8];

    // Ready must follow the state combinationally so the handshake closes in the same cycle.
    assign in_ready = (state == COLLECT) && !rst;
    assign xfer     = in_valid && in_ready;

    // Packet classification; an out-of-range src leaves src_hot empty.
    always_comb begin
        src_hot = '0;
        dup     = 1'b0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (32'(src) == i + 1) begin
                src_hot[i] = 1'b1;
                dup        = mask[i];
            end
        end
        dest_bad = (dest != ADDER_ADDR);
        src_bad  = (src_hot == '0);
        accept   = xfer && !dest_bad && !src_bad && !dup;
        complete = accept && ((mask | src_hot) == {NUM_PE{1'b1}});
    end

    // Membrane update with saturation before the threshold test.
    always_comb begin
        v_cur = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (idx == 2'(i)) v_cur = vmem[i];
        end
        sum = SW'(v_cur);
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            sum = sum + SW'(psum[i]);
        end
        v_sat = (sum > SW'({VW{1'b1}})) ? {VW{1'b1}} : sum[VW-1:0];
        spike = (v_sat >= VW'(THRESHOLD));
        v_new = spike ? (v_sat - VW'(THRESHOLD)) : v_sat;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (complete) state_nxt = SUM;
            SUM:     state_nxt = OUTPUT;
            OUTPUT:  if (out_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask      <= '0;
            idx       <= 2'd0;
            tstep     <= 8'd0;
            out_valid <= 1'b0;
            out_spike <= 1'b0;
            out_vmem  <= '0;
            out_idx   <= 2'd0;
            out_tstep <= 8'd0;
            err_dest  <= 1'b0;
            err_src   <= 1'b0;
            err_dup   <= 1'b0;
            for (int unsigned i = 0; i < NUM_PE; i++) psum[i] <= 8'd0;
            for (int unsigned i = 0; i < NUM_OUT; i++) vmem[i] <= '0;
        end else begin
            err_dest <= xfer && dest_bad;
            err_src  <= xfer && !dest_bad && src_bad;
            err_dup  <= xfer && !dest_bad && !src_bad && dup;
            if (accept) begin
                for (int unsigned i = 0; i < NUM_PE; i++) begin
                    if (src_hot[i]) begin
                        psum[i] <= data;
                        mask[i] <= 1'b1;
                    end
                end
            end
            case (state)
                SUM: begin
                    out_valid <= 1'b1;
                    out_spike <= spike;
                    out_vmem  <= v_new;
                    out_idx   <= idx;
                    out_tstep <= tstep;
                    for (int unsigned i = 0; i < NUM_OUT; i++) begin
                        if (idx == 2'(i)) vmem[i] <= v_new;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mask      <= '0;
                        if (idx == 2'(NUM_OUT - 1)) begin
                            idx   <= 2'd0;
                            tstep <= tstep + 8'd1;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboarded bench for psum_accumulator: a default instance plus one with THRESHOLD=4095
// to reach saturation.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_spike;
    logic [34:0] in_packet;
    logic [11:0] out_vmem;
    logic [1:0]  out_idx;
    logic [7:0]  out_tstep;
    logic        err_dest, err_src, err_dup;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_spike;
    logic [34:0] s_in_packet;
    logic [11:0] s_out_vmem;
    logic [1:0]  s_out_idx;
    logic [7:0]  s_out_tstep;
    logic        s_err_dest, s_err_src, s_err_dup;

    int tests = 0;
    int fails = 0;
    int n_dest = 0, n_src = 0, n_dup = 0;
    int b_dest, b_src, b_dup;

    logic [22:0] q_main[$];
    logic [22:0] q_sat[$];
    logic [22:0] m_got, m_exp, s_got, s_exp;

    always #5 clk = ~clk;

    psum_accumulator u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_spike(out_spike), .out_vmem(out_vmem), .out_idx(out_idx), .out_tstep(out_tstep),
        .err_dest(err_dest), .err_src(err_src), .err_dup(err_dup)
    );

    psum_accumulator #(.THRESHOLD(4095)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_packet(s_in_packet),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .out_spike(s_out_spike), .out_vmem(s_out_vmem), .out_idx(s_out_idx), .out_tstep(s_out_tstep),
        .err_dest(s_err_dest), .err_src(s_err_src), .err_dup(s_err_dup)
    );

    function automatic logic [22:0] exp_f(input bit spike, input int v, input int idx, input int ts);
        return {spike, 12'(v), 2'(idx), 8'(ts)};
    endfunction

    // Monitors: each handshake pops one expected result.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            m_got = {out_spike, out_vmem, out_idx, out_tstep};
            tests++;
            if (q_main.size() == 0) begin
                fails++;
                $display("FAIL main_unexpected got spike=%0d vmem=%0d idx=%0d ts=%0d",
                         m_got[22], m_got[21:10], m_got[9:8], m_got[7:0]);
            end else begin
                m_exp = q_main.pop_front();
                if (m_got !== m_exp) begin
                    fails++;
                    $display("FAIL main_result got spike=%0d vmem=%0d idx=%0d ts=%0d exp spike=%0d vmem=%0d idx=%0d ts=%0d",
                             m_got[22], m_got[21:10], m_got[9:8], m_got[7:0],
                             m_exp[22], m_exp[21:10], m_exp[9:8], m_exp[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (s_out_valid) begin
            s_got = {s_out_spike, s_out_vmem, s_out_idx, s_out_tstep};
            tests++;
            if (q_sat.size() == 0) begin
                fails++;
                $display("FAIL sat_unexpected got vmem=%0d", s_got[21:10]);
            end else begin
                s_exp = q_sat.pop_front();
                if (s_got !== s_exp) begin
                    fails++;
                    $display("FAIL sat_result got spike=%0d vmem=%0d idx=%0d ts=%0d exp spike=%0d vmem=%0d idx=%0d ts=%0d",
                             s_got[22], s_got[21:10], s_got[9:8], s_got[7:0],
                             s_exp[22], s_exp[21:10], s_exp[9:8], s_exp[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (err_dest) n_dest++;
        if (err_src)  n_src++;
        if (err_dup)  n_dup++;
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send(input bit sat, input logic [2:0] dest, input logic [2:0] src, input logic [7:0] p);
        int n;
        n = 0;
        if (sat) begin s_in_valid = 1'b1; s_in_packet = {dest, src, 21'h15A5A5, p}; end
        else     begin in_valid   = 1'b1; in_packet   = {dest, src, 21'h15A5A5, p}; end
        forever begin
            @(negedge clk);
            if (sat ? s_in_ready : in_ready) break;
            n++;
            if (n > 50) begin
                tests++; fails++;
                $display("FAIL send_timeout got=in_ready_low exp=accept_within_50");
                break;
            end
        end
        @(posedge clk); #1;
        if (sat) s_in_valid = 1'b0; else in_valid = 1'b0;
    endtask

    task automatic grp(input bit sat, input int a, input int b, input int c);
        send(sat, 3'd0, 3'd1, 8'(a));
        send(sat, 3'd0, 3'd2, 8'(b));
        send(sat, 3'd0, 3'd3, 8'(c));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_main.size() != 0 || q_sat.size() != 0) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                tests++; fails++;
                $display("FAIL drain_timeout got=%0d/%0d pending exp=0", q_main.size(), q_sat.size());
                q_main.delete(); q_sat.delete();
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_packet = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_packet = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_vmem", int'(out_vmem), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_tstep", int'(out_tstep), 0);
        chk("rst_err", int'({err_dest, err_src, err_dup}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Basic fire and latency
        q_main.push_back(exp_f(1, 11, 0, 0));
        grp(0, 20, 30, 25);
        @(negedge clk); chk("lat_sum_cycle", int'(out_valid), 0);
        @(negedge clk); chk("lat_out_valid", int'(out_valid), 1);
        @(negedge clk); chk("lat_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        drain();

        // Sub-threshold carry-over across time steps
        do_reset();
        q_main.push_back(exp_f(0, 30, 0, 0)); grp(0, 10, 10, 10);
        q_main.push_back(exp_f(0, 0, 1, 0));  grp(0, 0, 0, 0);
        q_main.push_back(exp_f(0, 0, 2, 0));  grp(0, 0, 0, 0);
        q_main.push_back(exp_f(0, 60, 0, 1)); grp(0, 10, 10, 10);
        q_main.push_back(exp_f(0, 0, 1, 1));  grp(0, 0, 0, 0);
        q_main.push_back(exp_f(0, 0, 2, 1));  grp(0, 0, 0, 0);
        q_main.push_back(exp_f(1, 0, 0, 2));  grp(0, 2, 1, 1);
        drain();

        // Errors and out-of-order arrival
        do_reset();
        b_dest = n_dest; b_src = n_src; b_dup = n_dup;
        q_main.push_back(exp_f(0, 15, 0, 0));
        send(0, 3'd0, 3'd3, 8'd5);
        send(0, 3'd1, 3'd1, 8'd77);
        send(0, 3'd0, 3'd0, 8'd33);
        send(0, 3'd0, 3'd3, 8'd9);
        send(0, 3'd0, 3'd1, 8'd4);
        send(0, 3'd0, 3'd2, 8'd6);
        drain();
        chk("err_dest_count", n_dest - b_dest, 1);
        chk("err_src_count", n_src - b_src, 1);
        chk("err_dup_count", n_dup - b_dup, 1);

        // Back-pressure on neurone 1
        out_ready = 1'b0;
        b_dup = n_dup;
        q_main.push_back(exp_f(0, 6, 1, 0));
        grp(0, 1, 2, 3);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        in_valid = 1'b1;
        in_packet = {3'd0, 3'd1, 21'h15A5A5, 8'd7};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_vmem", int'(out_vmem), 6);
            chk("bp_out_idx", int'(out_idx), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        q_main.push_back(exp_f(0, 9, 2, 0));
        send(0, 3'd0, 3'd2, 8'd1);
        send(0, 3'd0, 3'd3, 8'd1);
        drain();
        chk("bp_no_dup", n_dup - b_dup, 0);

        // Reset in the middle of a collection
        send(0, 3'd0, 3'd1, 8'd50);
        send(0, 3'd0, 3'd2, 8'd50);
        do_reset();
        b_dest = n_dest; b_src = n_src; b_dup = n_dup;
        send(0, 3'd0, 3'd3, 8'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_mid_no_out", int'(out_valid), 0);
        end
        @(posedge clk); #1;
        q_main.push_back(exp_f(0, 3, 0, 0));
        send(0, 3'd0, 3'd1, 8'd1);
        send(0, 3'd0, 3'd2, 8'd1);
        drain();
        chk("rst_mid_no_err", (n_dest - b_dest) + (n_src - b_src) + (n_dup - b_dup), 0);

        // Time-step wrap 255 -> 0
        do_reset();
        for (int ts = 0; ts < 256; ts++) begin
            for (int i = 0; i < 3; i++) begin
                q_main.push_back(exp_f(0, 0, i, ts));
                grp(0, 0, 0, 0);
            end
        end
        q_main.push_back(exp_f(0, 0, 0, 0));
        grp(0, 0, 0, 0);
        drain();

        // Saturation on the THRESHOLD=4095 instance
        for (int r = 0; r < 5; r++) begin
            q_sat.push_back(exp_f(0, 765 * (r + 1), 0, r)); grp(1, 255, 255, 255);
            q_sat.push_back(exp_f(0, 0, 1, r));             grp(1, 0, 0, 0);
            q_sat.push_back(exp_f(0, 0, 2, r));             grp(1, 0, 0, 0);
        end
        q_sat.push_back(exp_f(0, 4090, 0, 5)); grp(1, 255, 10, 0);
        q_sat.push_back(exp_f(0, 0, 1, 5));    grp(1, 0, 0, 0);
        q_sat.push_back(exp_f(0, 0, 2, 5));    grp(1, 0, 0, 0);
        q_sat.push_back(exp_f(1, 0, 0, 6));    grp(1, 255, 255, 255);
        q_sat.push_back(exp_f(0, 0, 1, 6));    grp(1, 0, 0, 0);
        q_sat.push_back(exp_f(0, 0, 2, 6));    grp(1, 0, 0, 0);
        q_sat.push_back(exp_f(0, 0, 0, 7));    grp(1, 0, 0, 0);
        drain();

        repeat (5) @(posedge clk);
        chk("main_queue_empty", q_main.size(), 0);
        chk("sat_queue_empty", q_sat.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
